decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: RV32I/RV32E field decode, register file, registered output slot, load-use interlock.
// Define DECODE_WB_BYPASS_EN to forward a same-edge register-file write into the captured rs values.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32  // 32 (RV32I) or 16 (RV32E) only
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_write,
  output logic            out_is_load,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_value,
  output logic [XLEN-1:0] out_rs2_value
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_write;
    logic            is_load;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } payload_t;

  payload_t        payload_d, payload_q;
  logic            valid_q, alive_q;
  logic [XLEN-1:0] rf_q [1:NREGS-1];

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, rs1_used, rs2_used, writes_rd, load_op, illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rs1_value, rs2_value;
  logic            hazard, fire_in, wb_en;

  function automatic logic reg_ok(input logic [4:0] idx);
    return (NREGS == 32) || !idx[4];
  endfunction

  assign opcode = in_instr[6:0];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];

  always_comb begin
    legal     = 1'b1;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    load_op   = 1'b0;
    imm32     = '0;
    case (opcode)
      OpLui, OpAuipc: begin
        writes_rd = 1'b1;
        imm32     = {in_instr[31:12], 12'b0};
      end
      OpJal: begin
        writes_rd = 1'b1;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      OpJalr: begin
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpBranch: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OpLoad: begin
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
        load_op   = 1'b1;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpImm: begin
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpReg: begin
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Any register index the instruction actually uses must exist in this register file.
  assign illegal = !legal || (rs1_used && !reg_ok(rs1)) || (rs2_used && !reg_ok(rs2)) ||
                   (writes_rd && !reg_ok(rd));

  assign wb_en = wb_write && (wb_rd != 5'd0) && reg_ok(wb_rd);

  always_comb begin
    rs1_value = '0;
    rs2_value = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (rs1 == 5'(i)) rs1_value = rf_q[i];
      if (rs2 == 5'(i)) rs2_value = rf_q[i];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && (wb_rd == rs1)) rs1_value = wb_value;
    if (wb_en && (wb_rd == rs2)) rs2_value = wb_value;
`endif
  end

  always_comb begin
    payload_d           = '0;
    payload_d.pc        = in_pc;
    payload_d.opcode    = opcode;
    payload_d.funct3    = in_instr[14:12];
    payload_d.funct7    = in_instr[31:25];
    payload_d.rs1       = rs1;
    payload_d.rs2       = rs2;
    payload_d.rd        = rd;
    payload_d.rd_write  = writes_rd && !illegal && (rd != 5'd0);
    payload_d.is_load   = load_op && !illegal;
    payload_d.illegal   = illegal;
    payload_d.imm       = illegal ? '0 : XLEN'($signed(imm32));
    payload_d.rs1_value = rs1_value;
    payload_d.rs2_value = rs2_value;
  end

  // Load-use: the consumer waits one cycle behind a held load writing one of its sources.
  assign hazard = valid_q && payload_q.is_load && (payload_q.rd != 5'd0) && in_valid &&
                  ((rs1_used && (rs1 == payload_q.rd)) || (rs2_used && (rs2 == payload_q.rd)));

  // alive_q keeps in_ready low until the first edge after reset release.
  assign in_ready = alive_q && (!valid_q || out_ready) && !hazard && !flush;
  assign fire_in  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      alive_q <= 1'b1;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (fire_in) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (fire_in) payload_q <= payload_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wb_en && (wb_rd == 5'(i))) rf_q[i] <= wb_value;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = payload_q.pc;
  assign out_opcode    = payload_q.opcode;
  assign out_funct3    = payload_q.funct3;
  assign out_funct7    = payload_q.funct7;
  assign out_rs1       = payload_q.rs1;
  assign out_rs2       = payload_q.rs2;
  assign out_rd        = payload_q.rd;
  assign out_rd_write  = payload_q.rd_write;
  assign out_is_load   = payload_q.is_load;
  assign out_illegal   = payload_q.illegal;
  assign out_imm       = payload_q.imm;
  assign out_rs1_value = payload_q.rs1_value;
  assign out_rs2_value = payload_q.rs2_value;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, load-use, stall, bypass, flush and reset.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        is_load;
    logic        illegal;
    logic [31:0] imm;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
  } exp_t;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] Byp = 32'h0000_00AA;
`else
  localparam logic [31:0] Byp = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, wb_write, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, wb_value;
  logic [4:0]  wb_rd;
  logic [31:0] out_pc, out_imm, out_rs1_value, out_rs2_value;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_write, out_is_load, out_illegal;

  logic        e_in_ready, e_out_valid, e_out_rd_write, e_out_is_load, e_out_illegal;
  logic [31:0] e_out_pc, e_out_imm, e_out_rs1_value, e_out_rs2_value;
  logic [6:0]  e_out_opcode, e_out_funct7;
  logic [2:0]  e_out_funct3;
  logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_write(wb_write), .wb_rd(wb_rd), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rd_write(out_rd_write), .out_is_load(out_is_load),
    .out_illegal(out_illegal), .out_imm(out_imm), .out_rs1_value(out_rs1_value),
    .out_rs2_value(out_rs2_value)
  );

  // RV32E instance fed the same stream; only its illegal-index behaviour is checked.
  decode_stage #(.NREGS(16)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_write(wb_write), .wb_rd(wb_rd), .wb_value(wb_value),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_opcode(e_out_opcode), .out_funct3(e_out_funct3), .out_funct7(e_out_funct7),
    .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
    .out_rd_write(e_out_rd_write), .out_is_load(e_out_is_load), .out_illegal(e_out_illegal),
    .out_imm(e_out_imm), .out_rs1_value(e_out_rs1_value), .out_rs2_value(e_out_rs2_value)
  );

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic rdw,
                              input logic ld, input logic ill, input logic [31:0] imm,
                              input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.pc = pc;  e.opcode = instr[6:0];  e.funct3 = instr[14:12];  e.funct7 = instr[31:25];
    e.rs1 = instr[19:15];  e.rs2 = instr[24:20];  e.rd = instr[11:7];
    e.rd_write = rdw;  e.is_load = ld;  e.illegal = ill;  e.imm = imm;
    e.rs1_value = v1;  e.rs2_value = v2;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    wb_write = 1'b1;  wb_rd = rd;  wb_value = val;
    @(posedge clk);
    #1 wb_write = 1'b0;
  endtask

  // Offer one instruction; push its expectation when the handshake is seen at a negedge.
  task automatic send(input exp_t e, input logic [31:0] instr, input bit push,
                      output int waits, output logic ov);
    bit acc = 1'b0;
    in_valid = 1'b1;  in_instr = instr;  in_pc = e.pc;  waits = 0;  ov = 1'bx;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(e);
        ov  = out_valid;
        acc = 1'b1;
        break;
      end
      waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr %h not accepted within 50 cycles", instr);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int   w, w2;
    logic ov, ov2;
    rst_n = 1'b0;  in_valid = 1'b0;  in_instr = '0;  in_pc = '0;  flush = 1'b0;
    wb_write = 1'b0;  wb_rd = '0;  wb_value = '0;  out_ready = 1'b1;

    fork
      forever begin
        exp_t obs, exp;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          obs = '{pc: out_pc, opcode: out_opcode, funct3: out_funct3, funct7: out_funct7,
                  rs1: out_rs1, rs2: out_rs2, rd: out_rd, rd_write: out_rd_write,
                  is_load: out_is_load, illegal: out_illegal, imm: out_imm,
                  rs1_value: out_rs1_value, rs2_value: out_rs2_value};
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h expected nothing", obs);
          end else begin
            exp = sb.pop_front();
            if (obs !== exp) begin
              errors++;
              $display("FAIL sb_pc%h: got %h expected %h", exp.pc, obs, exp);
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_payload", {out_pc, out_imm, out_rd, out_rd_write, out_rs1_value}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    check("ready_after_first_edge", in_ready, 1);
    @(posedge clk);
    #1;

    wb(5'd5, 32'h1234);  wb(5'd1, 32'h100);  wb(5'd2, 32'h22);  wb(5'd7, 32'h77);

    send(mk(32'hFFF28313, 32'h1000, 1, 0, 0, 32'hFFFF_FFFF, 32'h1234, 0), 32'hFFF28313, 1, w, ov);
    send(mk(32'h00000013, 32'h1004, 0, 0, 0, 0, 0, 0), 32'h00000013, 1, w, ov);
    send(mk(32'h12045637, 32'h1008, 1, 0, 0, 32'h1204_5000, 0, 0), 32'h12045637, 1, w, ov);
    send(mk(32'hFE20AE23, 32'h100C, 0, 0, 0, 32'hFFFF_FFFC, 32'h100, 32'h22), 32'hFE20AE23, 1,
         w, ov);
    send(mk(32'h00208463, 32'h1010, 0, 0, 0, 32'h8, 32'h100, 32'h22), 32'h00208463, 1, w, ov);
    send(mk(32'hFF9FF0EF, 32'h1014, 1, 0, 0, 32'hFFFF_FFF8, 0, 0), 32'hFF9FF0EF, 1, w, ov);

    // Load-use: LW x7 then ADD x8,x7,x2.
    send(mk(32'h0000A383, 32'h1018, 1, 1, 0, 0, 32'h100, 0), 32'h0000A383, 1, w, ov);
    check("lw_no_stall", w, 0);
    send(mk(32'h00238433, 32'h101C, 1, 0, 0, 0, 32'h77, 32'h22), 32'h00238433, 1, w, ov);
    check("hazard_stall_cycles", w, 1);
    check("hazard_bubble", ov, 0);
    send(mk(32'h01440493, 32'h1020, 1, 0, 0, 32'h14, 0, 0), 32'h01440493, 1, w, ov);
    check("alu_no_hazard", w, 0);

    // Back-pressure for three cycles while a stream is offered.
    out_ready = 1'b0;
    fork
      send(mk(32'h01500513, 32'h1024, 1, 0, 0, 32'h15, 0, 0), 32'h01500513, 1, w2, ov2);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold", {out_valid, out_rd, out_imm}, {1'b1, 5'd9, 32'h14});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stall_wait_cycles", w2, 3);
    send(mk(32'h01600593, 32'h1028, 1, 0, 0, 32'h16, 0, 0), 32'h01600593, 1, w, ov);

    // Same-edge write to x3 while ADD x4,x3,x3 is accepted, then again after it committed.
    wb_write = 1'b1;  wb_rd = 5'd3;  wb_value = 32'hAA;
    send(mk(32'h00318233, 32'h102C, 1, 0, 0, 0, Byp, Byp), 32'h00318233, 1, w, ov);
    wb_write = 1'b0;
    check("bypass_no_stall", w, 0);
    send(mk(32'h00318233, 32'h1030, 1, 0, 0, 0, 32'hAA, 32'hAA), 32'h00318233, 1, w, ov);

    send(mk(32'h0000007F, 32'h1034, 0, 0, 1, 0, 0, 0), 32'h0000007F, 1, w, ov);
    send(mk(32'h002088B3, 32'h1038, 1, 0, 0, 0, 32'h100, 32'h22), 32'h002088B3, 1, w, ov);
    @(negedge clk);
    check("rv32e_x17_illegal", {e_out_valid, e_out_illegal, e_out_rd_write}, 3'b110);
    @(posedge clk);
    #1;

    // Flush with a held instruction and a new offer; the same-edge write to x13 must commit.
    out_ready = 1'b0;
    send(mk(32'h00000013, 32'h2000, 0, 0, 0, 0, 0, 0), 32'h00000013, 0, w, ov);
    in_valid = 1'b1;  in_instr = 32'h01500513;  in_pc = 32'h2004;  flush = 1'b1;
    wb_write = 1'b1;  wb_rd = 5'd13;  wb_value = 32'h5A;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;  flush = 1'b0;  wb_write = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(32'h00068733, 32'h2008, 1, 0, 0, 0, 32'h5A, 0), 32'h00068733, 1, w, ov);
    @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Asynchronous reset mid-cycle with one instruction held and another offered.
    send(mk(32'h01400493, 32'h3000, 0, 0, 0, 0, 0, 0), 32'h01400493, 0, w, ov);
    in_valid = 1'b1;  in_instr = 32'h01500513;
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_out_valid", out_valid, 0);
    check("reset_mid_in_ready", in_ready, 0);
    check("reset_mid_payload", {out_pc, out_imm, out_rd}, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;  out_ready = 1'b1;
    send(mk(32'h00318233, 32'h4000, 1, 0, 0, 0, 0, 0), 32'h00318233, 1, w, ov);
    send(mk(32'h00238433, 32'h4004, 1, 0, 0, 0, 0, 0), 32'h00238433, 1, w, ov);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
